wb_cmd_master: RTL
==================

# wb_cmd_master

Wishbone classic initiator that turns single-word command requests into bus cycles toward Wishbone responders such as the signal generator register block. It accepts one read or write command on a valid/ready interface and drives `cyc`/`stb`/`we`/`addr`/`data` until the responder acks. It returns the read data, or an error if the ack never arrives, on a valid/ready response interface. It sits between a local controller (test sequencer, LA bridge, or future CPU-less config engine) and the user-area Wishbone bus.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 16: maximum bus cycles waited for `i_wb_ack`; legal range 2..255.

Ports (clock and reset first):
- `i_wb_clk` input 1: single clock; every register updates on its rising edge.
- `i_wb_rst` input 1: reset, synchronous, active-high.
- `i_cmd_valid` input 1: command request.
- `o_cmd_ready` output 1: command accepted when high together with `i_cmd_valid`.
- `i_cmd_we` input 1: 1 = write, 0 = read.
- `i_cmd_addr` input 32: target address.
- `i_cmd_data` input 32: write data; ignored on reads.
- `o_rsp_valid` output 1: response available.
- `i_rsp_ready` input 1: response consumed when high together with `o_rsp_valid`.
- `o_rsp_data` output 32: read data; 0 for writes and for errors.
- `o_rsp_err` output 1: 1 = timeout abort.
- `o_wb_cyc` output 1: bus cycle.
- `o_wb_stb` output 1: strobe; always equal to `o_wb_cyc`.
- `o_wb_we` output 1: write enable.
- `o_wb_addr` output 32: address.
- `o_wb_data` output 32: write data.
- `i_wb_ack` input 1: responder ack.
- `i_wb_data` input 32: responder read data.
- `o_busy` output 1: high in BUS or RESP.

## Operation
- FSM states:
  - IDLE:
    - `o_cmd_ready`=1.
    - On `i_cmd_valid`, latch `we`/`addr`/`data` into the bus registers, clear the timeout counter, go to BUS.
  - BUS:
    - `o_wb_cyc`=`o_wb_stb`=1; `o_wb_we`/`o_wb_addr`/`o_wb_data` are held stable.
    - On `i_wb_ack`: capture `i_wb_data` into `o_rsp_data` for reads, or 0 for writes; set `o_rsp_err`=0; go to RESP.
    - Otherwise, if counter == `TIMEOUT_CYCLES`-1: set `o_rsp_data`=0, `o_rsp_err`=1, go to RESP.
    - Otherwise, counter +1.
  - RESP:
    - `o_rsp_valid`=1; `o_rsp_data`/`o_rsp_err` are held stable.
    - On `i_rsp_ready`, go to IDLE.
- All outputs are registered or decoded directly from the state register; no combinational path from `i_wb_ack` to any output.
- Timeout counter is 8 bits. It never wraps, because the abort fires at `TIMEOUT_CYCLES`-1.
- Reset values: state IDLE, `o_cmd_ready`=1, `o_wb_cyc`=`o_wb_stb`=`o_wb_we`=0, `o_wb_addr`=`o_wb_data`=0, `o_rsp_valid`=0, `o_rsp_data`=0, `o_rsp_err`=0, `o_busy`=0, counter 0.
- Boundary rules:
  - Ack on the same edge the counter hits `TIMEOUT_CYCLES`-1: ack wins; normal response, `err`=0.
  - `i_wb_ack` while in IDLE or RESP: ignored; no state or data change.
  - `i_cmd_valid` while not in IDLE: not accepted (`o_cmd_ready`=0); the command must be held by the source.
  - Reset asserted mid-BUS: `o_wb_cyc`/`o_wb_stb` are low in the cycle after the reset edge; the pending command is discarded and no response is issued.
  - `i_rsp_ready` held high in advance: RESP lasts exactly one cycle.

## Timing
- Command handshake at edge T: `o_wb_cyc`/`o_wb_stb` high from cycle T+1.
- Ack sampled at edge T+k (k≥1): `cyc`/`stb` high for exactly k cycles. `o_rsp_valid` is high from cycle T+k, and `cyc` is low in that same cycle.
- Timeout: `cyc` high for exactly `TIMEOUT_CYCLES` cycles, then `o_rsp_valid`=1 with `err`=1.
- Response handshake at edge R: `o_cmd_ready`=1 from cycle R+1; a new command can be accepted at edge R+1.
- Best case, with ack in the first bus cycle and `i_rsp_ready` held high: one command every 3 cycles.
- `cyc` always drops for at least one cycle between consecutive transactions.

## Test plan
- Reset check: assert `i_wb_rst` for 2 cycles -> all outputs at their reset values; `o_cmd_ready`=1.
- Write: `we`=1, addr 0x3000_0004, data 0x0000_0005; responder acks on the 2nd bus cycle -> `cyc` high 2 cycles with stable addr/data; `rsp_valid`=1, `rsp_data`=0, `err`=0.
- Read: addr 0x3000_0008; responder acks on the 1st bus cycle with data 0xA5A5_0F0F -> `rsp_data`=0xA5A5_0F0F, `err`=0; with `i_rsp_ready` held high, back-to-back commands are accepted every 3 cycles.
- Timeout: `TIMEOUT_CYCLES`=16, no ack -> `cyc` high exactly 16 cycles; `rsp_err`=1, `rsp_data`=0. Second run: ack arrives in bus cycle 16 -> `err`=0 with valid data.
- Backpressure and spurious ack: hold `i_rsp_ready`=0 for 5 cycles and pulse `i_wb_ack` during RESP and during IDLE -> response data unchanged, `o_cmd_ready`=0 until the response handshake, no new bus cycle.
- Reset mid-BUS: assert reset in bus cycle 3 of a read -> `cyc`=0 in the next cycle, no `rsp_valid`; a following command completes normally.

Source files
------------

// File: rtl/wb_cmd_master_if.sv
// wb_cmd_master_if: command/response handshakes plus Wishbone classic master signals.
interface wb_cmd_master_if;
    logic        i_cmd_valid;
    logic        o_cmd_ready;
    logic        i_cmd_we;
    logic [31:0] i_cmd_addr;
    logic [31:0] i_cmd_data;
    logic        o_rsp_valid;
    logic        i_rsp_ready;
    logic [31:0] o_rsp_data;
    logic        o_rsp_err;
    logic        o_wb_cyc;
    logic        o_wb_stb;
    logic        o_wb_we;
    logic [31:0] o_wb_addr;
    logic [31:0] o_wb_data;
    logic        i_wb_ack;
    logic [31:0] i_wb_data;
    logic        o_busy;

    modport master (
        input  i_cmd_valid, i_cmd_we, i_cmd_addr, i_cmd_data, i_rsp_ready, i_wb_ack, i_wb_data,
        output o_cmd_ready, o_rsp_valid, o_rsp_data, o_rsp_err,
               o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data, o_busy
    );

    modport slave (
        output i_cmd_valid, i_cmd_we, i_cmd_addr, i_cmd_data, i_rsp_ready, i_wb_ack, i_wb_data,
        input  o_cmd_ready, o_rsp_valid, o_rsp_data, o_rsp_err,
               o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data, o_busy
    );
endinterface

// File: rtl/wb_cmd_master.sv
// wb_cmd_master: single-command Wishbone classic initiator with ack timeout.
module wb_cmd_master #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic            i_wb_clk,
    input  logic            i_wb_rst,
    wb_cmd_master_if.master bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUS  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [1:0]  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic        rsp_err_q, rsp_err_d;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        we_d       = we_q;
        addr_d     = addr_q;
        data_d     = data_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        case (state_q)
            S_IDLE: if (bus.i_cmd_valid) begin
                we_d    = bus.i_cmd_we;
                addr_d  = bus.i_cmd_addr;
                data_d  = bus.i_cmd_data;
                cnt_d   = 8'd0;
                state_d = S_BUS;
            end
            // ack takes priority over the abort on the final allowed cycle
            S_BUS: if (bus.i_wb_ack) begin
                rsp_data_d = we_q ? 32'd0 : bus.i_wb_data;
                rsp_err_d  = 1'b0;
                state_d    = S_RESP;
            end else if (cnt_q == CNT_LAST) begin
                rsp_data_d = 32'd0;
                rsp_err_d  = 1'b1;
                state_d    = S_RESP;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
            S_RESP: if (bus.i_rsp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_wb_clk) begin
        if (i_wb_rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= 8'd0;
            we_q       <= 1'b0;
            addr_q     <= 32'd0;
            data_q     <= 32'd0;
            rsp_data_q <= 32'd0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    assign bus.o_cmd_ready = state_q == S_IDLE;
    assign bus.o_wb_cyc    = state_q == S_BUS;
    assign bus.o_wb_stb    = state_q == S_BUS;
    assign bus.o_rsp_valid = state_q == S_RESP;
    assign bus.o_busy      = state_q != S_IDLE;
    assign bus.o_wb_we     = we_q;
    assign bus.o_wb_addr   = addr_q;
    assign bus.o_wb_data   = data_q;
    assign bus.o_rsp_data  = rsp_data_q;
    assign bus.o_rsp_err   = rsp_err_q;
endmodule
